// File: rtl/rtclock_pps_servo.sv
// rtl/rtclock_pps_servo.sv - PPS period measurement and clamped integral servo for the RTC increment
// Optional missing-PPS holdover timeout is built when RTCLOCK_SERVO_HOLDOVER_EN is defined.
module rtclock_pps_servo #(
  parameter logic [31:0] C_EXPECTED_CYCLES = 32'd125000000,
  parameter logic [15:0] C_KI              = 16'd17,
  parameter int unsigned C_KI_SHIFT        = 1,
  parameter logic [31:0] C_MAX_ERR         = 32'd1000,
  parameter logic [31:0] C_LOCK_ERR        = 32'd2,
  parameter logic [15:0] C_LOCK_SAMPLES    = 16'd4,
  parameter logic [31:0] C_DELTA_MIN       = 32'h7F000000,
  parameter logic [31:0] C_DELTA_MAX       = 32'h81000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        pps,
  input  logic [31:0] delta_init,
  output logic [31:0] corrected_delta,
  output logic [31:0] last_count,
  output logic [31:0] last_err,
  output logic        sample_valid,
  output logic        locked,
  output logic        holdover,
  output logic [15:0] outlier_cnt
);

  typedef enum logic [1:0] {ST_DISABLED, ST_ACQUIRE, ST_TRACK, ST_HOLDOVER} state_t;

`ifdef RTCLOCK_SERVO_HOLDOVER_EN
  localparam logic [31:0] C_TIMEOUT = C_EXPECTED_CYCLES + (C_EXPECTED_CYCLES >> 1);
`endif

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] last_count_q, last_count_d, last_err_q, last_err_d;
  logic        s1v_q, s1v_d, s2v_q, s2v_d;
  logic        outl_q, outl_d, inband_q, inband_d;
  logic [47:0] adj_q, adj_d;
  logic [31:0] delta_q, delta_d;
  logic        sample_valid_q, sample_valid_d;
  logic        locked_q, locked_d, holdover_q, holdover_d;
  logic [15:0] outlier_cnt_q, outlier_cnt_d, lock_run_q, lock_run_d;
  logic [1:0]  out_run_q, out_run_d;

  logic               pps_edge;
  logic [32:0]        err_ext, abs_err;
  logic signed [47:0] prod;
  logic signed [48:0] new_delta;
  logic [31:0]        delta_clamped;
  logic [15:0]        lock_run_inc;

  always_comb begin
    pps_edge = sync2_q & ~dly_q;
    sync1_d  = pps;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    cnt_d    = pps_edge ? 32'd1 : ((cnt_q == '1) ? cnt_q : cnt_q + 32'd1);

    // Stage 2 works from the registered error so the multiplier sees a full cycle.
    err_ext  = {last_err_q[31], last_err_q};
    abs_err  = last_err_q[31] ? (33'd0 - err_ext) : err_ext;
    prod     = $signed({{16{last_err_q[31]}}, last_err_q}) * $signed({32'd0, C_KI});
    adj_d    = prod >>> C_KI_SHIFT;
    outl_d   = (abs_err > {1'b0, C_MAX_ERR}) || (last_count_q == '1);
    inband_d = (abs_err <= {1'b0, C_LOCK_ERR});

    new_delta = $signed({17'd0, delta_q}) - $signed({adj_q[47], adj_q});
    if (new_delta < $signed({17'd0, C_DELTA_MIN}))      delta_clamped = C_DELTA_MIN;
    else if (new_delta > $signed({17'd0, C_DELTA_MAX})) delta_clamped = C_DELTA_MAX;
    else                                                delta_clamped = new_delta[31:0];
    lock_run_inc = (lock_run_q == '1) ? lock_run_q : lock_run_q + 16'd1;
  end

  always_comb begin
    state_d        = state_q;
    delta_d        = delta_q;
    locked_d       = locked_q;
    holdover_d     = holdover_q;
    lock_run_d     = lock_run_q;
    out_run_d      = out_run_q;
    outlier_cnt_d  = outlier_cnt_q;
    sample_valid_d = 1'b0;
    last_count_d   = last_count_q;
    last_err_d     = last_err_q;
    s1v_d          = enable && (state_q == ST_TRACK) && pps_edge;
    s2v_d          = enable && s1v_q;

    if (s1v_d) begin
      last_count_d = cnt_q;
      last_err_d   = cnt_q - C_EXPECTED_CYCLES;
    end

    if (!enable) begin
      state_d    = ST_DISABLED;
      locked_d   = 1'b0;
      holdover_d = 1'b0;
      lock_run_d = '0;
      out_run_d  = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d   = ST_ACQUIRE;
          delta_d   = delta_init;
          out_run_d = '0;
        end
        ST_ACQUIRE: begin
          out_run_d = '0;
          if (pps_edge) state_d = ST_TRACK;
        end
        ST_HOLDOVER: begin
          out_run_d = '0;
          if (pps_edge) begin
            state_d    = ST_TRACK;
            holdover_d = 1'b0;
          end
        end
        default: begin
          if (s2v_q) begin
            if (outl_q) begin
              outlier_cnt_d = (outlier_cnt_q == '1) ? outlier_cnt_q : outlier_cnt_q + 16'd1;
              if (out_run_q == 2'd2) begin
                state_d    = ST_ACQUIRE;
                locked_d   = 1'b0;
                lock_run_d = '0;
                out_run_d  = '0;
              end else begin
                out_run_d = out_run_q + 2'd1;
              end
            end else begin
              delta_d        = delta_clamped;
              sample_valid_d = 1'b1;
              out_run_d      = '0;
              if (inband_q) begin
                lock_run_d = lock_run_inc;
                if (lock_run_inc >= C_LOCK_SAMPLES) locked_d = 1'b1;
              end else begin
                lock_run_d = '0;
                locked_d   = 1'b0;
              end
            end
          end
`ifdef RTCLOCK_SERVO_HOLDOVER_EN
          if (!pps_edge && (cnt_q == C_TIMEOUT)) begin
            state_d    = ST_HOLDOVER;
            holdover_d = 1'b1;
            locked_d   = 1'b0;
            lock_run_d = '0;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_DISABLED;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      dly_q          <= 1'b0;
      cnt_q          <= '0;
      last_count_q   <= '0;
      last_err_q     <= '0;
      s1v_q          <= 1'b0;
      s2v_q          <= 1'b0;
      outl_q         <= 1'b0;
      inband_q       <= 1'b0;
      adj_q          <= '0;
      delta_q        <= 32'h80000000;
      sample_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      holdover_q     <= 1'b0;
      outlier_cnt_q  <= '0;
      lock_run_q     <= '0;
      out_run_q      <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      dly_q          <= dly_d;
      cnt_q          <= cnt_d;
      last_count_q   <= last_count_d;
      last_err_q     <= last_err_d;
      s1v_q          <= s1v_d;
      s2v_q          <= s2v_d;
      outl_q         <= outl_d;
      inband_q       <= inband_d;
      adj_q          <= adj_d;
      delta_q        <= delta_d;
      sample_valid_q <= sample_valid_d;
      locked_q       <= locked_d;
      holdover_q     <= holdover_d;
      outlier_cnt_q  <= outlier_cnt_d;
      lock_run_q     <= lock_run_d;
      out_run_q      <= out_run_d;
    end
  end

  assign corrected_delta = delta_q;
  assign last_count      = last_count_q;
  assign last_err        = last_err_q;
  assign sample_valid    = sample_valid_q;
  assign locked          = locked_q;
  assign holdover        = holdover_q;
  assign outlier_cnt     = outlier_cnt_q;

endmodule

// File: tb/tb_rtclock_pps_servo.sv
// tb/tb_rtclock_pps_servo.sv - randomized self-checking bench for rtclock_pps_servo against a behavioural model
module tb_rtclock_pps_servo;

  localparam int M_OFF = 0, M_ACQ = 1, M_TRK = 2, M_HOLD = 3;
`ifdef RTCLOCK_SERVO_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, enable, pps;
  logic [31:0] delta_init;
  logic [31:0] corrected_delta, last_count, last_err;
  logic        sample_valid, locked, holdover;
  logic [15:0] outlier_cnt;

  always #5 clk = ~clk;

  rtclock_pps_servo #(.C_EXPECTED_CYCLES(32'd1000)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pps(pps), .delta_init(delta_init),
    .corrected_delta(corrected_delta), .last_count(last_count), .last_err(last_err),
    .sample_valid(sample_valid), .locked(locked), .holdover(holdover), .outlier_cnt(outlier_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: edge times come from the stimulus, samples are queued with their commit cycle.
  int          edge_q[$];
  int          pend_due[$];
  logic [31:0] pend_n[$];
  int          m_state;
  longint      m_cnt;
  logic [31:0] m_delta, m_lc, m_le;
  int          m_oc, m_lrun, m_orun;
  bit          m_sv, m_locked, m_hold, m_edge;

  task automatic model_commit(input logic [31:0] n);
    logic signed [31:0] e32;
    longint e, ae, adj, nd;
    e32 = n - 32'd1000;
    e   = e32;
    ae  = (e < 0) ? -e : e;
    if (ae > 1000 || n == 32'hFFFFFFFF) begin
      if (m_oc < 65535) m_oc++;
      m_orun++;
      if (m_orun == 3) begin
        m_locked = 0; m_lrun = 0; m_state = M_ACQ; m_orun = 0;
      end
    end else begin
      adj = (e * 17) >>> 1;
      nd  = longint'({32'd0, m_delta}) - adj;
      if (nd < 64'sh7F000000) nd = 64'sh7F000000;
      if (nd > 64'sh81000000) nd = 64'sh81000000;
      m_delta = nd[31:0];
      m_sv    = 1;
      m_orun  = 0;
      if (ae <= 2) begin
        m_lrun++;
        if (m_lrun >= 4) m_locked = 1;
      end else begin
        m_lrun = 0; m_locked = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    while (edge_q.size() > 0 && edge_q[0] < cyc) void'(edge_q.pop_front());
    m_edge = (edge_q.size() > 0 && edge_q[0] == cyc);
    if (!resetn) begin
      m_state = M_OFF; m_delta = 32'h80000000; m_lc = 0; m_le = 0; m_oc = 0;
      m_sv = 0; m_locked = 0; m_hold = 0; m_lrun = 0; m_orun = 0; m_cnt = 0;
      pend_due.delete(); pend_n.delete();
    end else begin
      m_sv = 0;
      if (!enable) begin
        m_state = M_OFF; m_locked = 0; m_hold = 0; m_lrun = 0; m_orun = 0;
        pend_due.delete(); pend_n.delete();
      end else begin
        case (m_state)
          M_OFF: begin m_state = M_ACQ; m_delta = delta_init; m_orun = 0; end
          M_ACQ: begin m_orun = 0; if (m_edge) m_state = M_TRK; end
          M_HOLD: begin
            m_orun = 0;
            if (m_edge) begin m_state = M_TRK; m_hold = 0; end
          end
          default: begin
            if (pend_due.size() > 0 && pend_due[0] == cyc) model_commit(pend_n[0]);
            if (m_edge) begin
              m_lc = m_cnt[31:0];
              m_le = m_lc - 32'd1000;
              pend_due.push_back(cyc + 2);
              pend_n.push_back(m_lc);
            end else if (HOLD_EN && m_cnt == 1500) begin
              m_state = M_HOLD; m_hold = 1; m_locked = 0; m_lrun = 0;
            end
          end
        endcase
      end
      while (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_due.pop_front());
        void'(pend_n.pop_front());
      end
      if (m_edge) m_cnt = 1;
      else if (m_cnt < 64'hFFFFFFFF) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("corrected_delta", corrected_delta, m_delta);
      chk("last_count", last_count, m_lc);
      chk("last_err", last_err, m_le);
      chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_sv});
      chk("locked", {31'd0, locked}, {31'd0, m_locked});
      chk("holdover", {31'd0, holdover}, {31'd0, m_hold});
      chk("outlier_cnt", {16'd0, outlier_cnt}, m_oc[31:0]);
    end
  end

  int last_rise = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic fire();
    pps = 1'b1;
    last_rise = cyc;
    edge_q.push_back(cyc + 2);
    step();
    step();
    pps = 1'b0;
  endtask

  task automatic pps_after(input int p);
    while (cyc < last_rise + p) step();
    fire();
  endtask

  // Called right after pps_after returns (edge cycle E): checks E+2 quiet and E+3 result.
  task automatic pin_sample(input logic exp_sv, input logic [31:0] exp_delta);
    steps(2);
    chk("pin_sv_e2", {31'd0, sample_valid}, 32'd0);
    step();
    chk("pin_sv_e3", {31'd0, sample_valid}, {31'd0, exp_sv});
    chk("pin_delta", corrected_delta, exp_delta);
  endtask

  initial begin
    int r, p;
    resetn = 1'b0; enable = 1'b0; pps = 1'b0; delta_init = 32'h80000000;
    steps(3);
    chk("rst_delta", corrected_delta, 32'h80000000);
    chk("rst_last_count", last_count, 32'd0);
    chk("rst_outlier", {16'd0, outlier_cnt}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    resetn = 1'b1;
    steps(2);
    enable = 1'b1;
    steps(3);

    fire();
    for (int i = 0; i < 3; i++) begin
      pps_after(1000);
      pin_sample(1'b1, 32'h80000000);
      chk("pre_lock", {31'd0, locked}, 32'd0);
    end
    pps_after(1000);
    pin_sample(1'b1, 32'h80000000);
    chk("lock_4th", {31'd0, locked}, 32'd1);
    chk("err_zero", last_err, 32'd0);

    pps_after(1002);
    pin_sample(1'b1, 32'h7FFFFFEF);
    chk("err_plus2", last_err, 32'd2);
    chk("count_1002", last_count, 32'd1002);
    pps_after(1002);
    pin_sample(1'b1, 32'h7FFFFFDE);

    enable = 1'b0;
    steps(2);
    delta_init = 32'h80FFFFF0;
    enable = 1'b1;
    steps(2);
    chk("init_load", corrected_delta, 32'h80FFFFF0);
    chk("unlock_dis", {31'd0, locked}, 32'd0);
    fire();
    pps_after(998);
    pin_sample(1'b1, 32'h81000000);
    chk("err_minus2", last_err, 32'hFFFFFFFE);
    pps_after(1000);
    pps_after(1000);

`ifndef RTCLOCK_SERVO_HOLDOVER_EN
    pps_after(2500);
    pin_sample(1'b0, 32'h81000000);
    chk("outlier_1", {16'd0, outlier_cnt}, 32'd1);
    pps_after(1000);
    pin_sample(1'b1, 32'h81000000);
    chk("relock", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 3; i++) pps_after(2500);
    steps(3);
    chk("outlier_4", {16'd0, outlier_cnt}, 32'd4);
    chk("unlock_outl", {31'd0, locked}, 32'd0);
    pps_after(1000);
    pin_sample(1'b0, 32'h81000000);
    pps_after(1000);
    pin_sample(1'b1, 32'h81000000);
`else
    pps_after(1000);
    pin_sample(1'b1, 32'h81000000);
    chk("hold_prelock", {31'd0, locked}, 32'd1);
    while (cyc < last_rise + 2 + 1500) step();
    chk("hold_not_yet", {31'd0, holdover}, 32'd0);
    step();
    chk("hold_set", {31'd0, holdover}, 32'd1);
    chk("hold_unlock", {31'd0, locked}, 32'd0);
    steps(300);
    fire();
    steps(2);
    chk("hold_first_sv", {31'd0, sample_valid}, 32'd0);
    chk("hold_clear", {31'd0, holdover}, 32'd0);
    pps_after(1000);
    pin_sample(1'b1, 32'h81000000);
`endif

    pps_after(1000);
    step();
    enable = 1'b0;
    steps(2);
    chk("abort_sv", {31'd0, sample_valid}, 32'd0);
    chk("abort_locked", {31'd0, locked}, 32'd0);

    delta_init = 32'h80000100;
    enable = 1'b1;
    steps(3);
    fire();
    pps_after(1000);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rst2_delta", corrected_delta, 32'h80000000);
    chk("rst2_count", last_count, 32'd0);
    chk("rst2_outlier", {16'd0, outlier_cnt}, 32'd0);
    step();
    chk("rst2_sv", {31'd0, sample_valid}, 32'd0);
    steps(3);

    fire();
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        enable = 1'b0;
        steps($urandom_range(2, 20));
        delta_init = $urandom_range(32'h80800000, 32'h7F800000);
        enable = 1'b1;
        steps(3);
        fire();
      end else begin
        if (r < 70)      p = $urandom_range(990, 1010);
        else if (r < 85) p = $urandom_range(600, 1400);
        else             p = $urandom_range(2100, 2600);
        pps_after(p);
      end
    end
    steps(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
